// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbitration path.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_e;

    localparam int DEF_LOCK_TIMEOUT = 1024;

    // Round-robin successor of an index, wrapping to 0 after num-1.
    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned num);
        return (idx + 32'd1 >= num) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr_i,
// wrapping modulo NUM_REQ. Shared with the planned RX-side DMA scheduler.
module uart_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [IW-1:0]      rr_ptr_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      grant_idx_o,
    output logic               any_valid_o
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx_sel;

    // Walk the offsets downward so the smallest offset from rr_ptr_i wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_valid_o = |req_valid_i;
        sum         = '0;
        idx_sel     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_i} + (IW+1)'(k);
            if (sum >= (IW+1)'(NUM_REQ)) begin
                sum = sum - (IW+1)'(NUM_REQ);
            end
            idx_sel = sum[IW-1:0];
            if (enable_i && req_valid_i[idx_sel]) begin
                grant_o          = '0;
                grant_o[idx_sel] = 1'b1;
                grant_idx_o      = idx_sel;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte streams: round-robin per byte,
// with a packet lock that keeps a multi-byte message from being interleaved.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int LOCK_TIMEOUT = uart_pkg::DEF_LOCK_TIMEOUT,
    parameter  int TO_W         = 16,
    localparam int IW           = $clog2(NUM_REQ)
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 clear_req,
    output logic                 busy,
    output logic [IW-1:0]        grant_id,
    output logic                 locked
);

    localparam bit            TIMEOUT_EN = (LOCK_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

    arb_state_e      state_q,   state_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [IW-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [IW-1:0]   grant_q,   grant_d;
    logic            locked_q,  locked_d;
    logic [TO_W-1:0] to_cnt_q,  to_cnt_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic [NUM_REQ-1:0] grant_mask;
    logic [NUM_REQ-1:0] hold_ready;
    logic               accept;
    logic [7:0]         acc_byte;
    logic               acc_last;
    logic [IW-1:0]      ptr_after_grant;

    uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .enable_i    ((state_q == ST_IDLE) && !wb_rst_i),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .any_valid_o (arb_any)
    );

    // In HOLD only the locked owner may be accepted; ready is gated off in reset
    // so no byte is consumed by a cycle whose state update is discarded.
    always_comb begin
        grant_mask          = '0;
        grant_mask[grant_q] = 1'b1;
        hold_ready          = ((state_q == ST_HOLD) && !wb_rst_i) ? (req_valid & grant_mask) : '0;
        req_ready           = arb_grant | hold_ready;
        accept              = |req_ready;
        acc_byte            = '0;
        acc_last            = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                acc_byte = req_data[8*i +: 8];
                acc_last = req_last[i];
            end
        end
        ptr_after_grant = IW'(next_ptr(32'(grant_q), NUM_REQ));
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        locked_d  = locked_q;
        to_cnt_d  = to_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any && accept) begin
                    tx_data_d = acc_byte;
                    grant_d   = arb_idx;
                    locked_d  = ~acc_last;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (clear_req) begin
                    if (locked_q) begin
                        to_cnt_d = '0;
                        state_d  = ST_HOLD;
                    end else begin
                        rr_ptr_d = ptr_after_grant;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                // An arriving byte beats a timeout that expires in the same cycle.
                if (accept) begin
                    tx_data_d = acc_byte;
                    locked_d  = ~acc_last;
                    state_d   = ST_SEND;
                end else if (TIMEOUT_EN && (to_cnt_q == TO_LAST)) begin
                    locked_d = 1'b0;
                    rr_ptr_d = ptr_after_grant;
                    state_d  = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            tx_data_q <= '0;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            locked_q  <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            locked_q  <= locked_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = (state_q == ST_SEND);
    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: arbitration vector table, scoreboarded frame order,
// and hand sequences for packet lock, lock timeout and reset mid-frame.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LOCK_TO = 8;

    logic        clk = 1'b0;
    logic        wbRst = 1'b1;
    logic [3:0]  reqValid = '0;
    logic [31:0] reqData = '0;
    logic [3:0]  reqLast = '0;
    logic        clearReq = 1'b0;
    logic [3:0]  reqReady;
    logic [7:0]  txData;
    logic        txStart;
    logic        busy;
    logic [1:0]  grantId;
    logic        locked;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        logic       isLocked;
    } frame_t;

    typedef struct {
        logic [3:0] valid;
        logic [1:0] expId;
    } arbVec_t;

    frame_t     sbQueue[$];
    arbVec_t    vecs[9];
    int         assertCount = 0;
    int         failCount = 0;
    bit         autoClear = 1'b0;
    bit         manualClear = 1'b0;
    logic [7:0] feedData[4][4];
    logic       feedLast[4][4];
    int         feedCnt[4];
    int         feedIdx[4];

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .LOCK_TIMEOUT(LOCK_TO), .TO_W(16)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (wbRst),
        .req_valid (reqValid),
        .req_data  (reqData),
        .req_last  (reqLast),
        .req_ready (reqReady),
        .tx_data   (txData),
        .tx_start  (txStart),
        .clear_req (clearReq),
        .busy      (busy),
        .grant_id  (grantId),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failBound(input string name, input int cycles);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: wait bound of %0d cycles expired", name, cycles);
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data, input logic [3:0] last);
        reqValid = valid;
        reqData  = data;
        reqLast  = last;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sbPush(input logic [1:0] id, input logic [7:0] data, input logic isLocked);
        frame_t f;
        f.id       = id;
        f.data     = data;
        f.isLocked = isLocked;
        sbQueue.push_back(f);
    endtask

    task automatic resetDut();
        nextCycle();
        wbRst = 1'b1;
        manualClear = 1'b0;
        applyStimulus(4'h0, 32'h0, 4'h0);
        nextCycle();
        nextCycle();
        wbRst = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < maxCycles);
        if (busy) failBound(name, maxCycles);
        nextCycle();
    endtask

    task automatic clearFeeds();
        for (int i = 0; i < NUM_REQ; i++) begin
            feedCnt[i] = 0;
            feedIdx[i] = 0;
        end
    endtask

    task automatic addFeed(input int req, input logic [7:0] data, input logic last);
        feedData[req][feedCnt[req]] = data;
        feedLast[req][feedCnt[req]] = last;
        feedCnt[req]++;
    endtask

    // Each requester presents its queued bytes in order, advancing only on accept.
    task automatic runRequesters(input int maxCycles, input string name);
        logic [3:0] rdy;
        int         cyc;
        bit         allDone;
        cyc = 0;
        forever begin
            allDone = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (feedIdx[i] < feedCnt[i]) begin
                    reqValid[i]       = 1'b1;
                    reqData[8*i +: 8] = feedData[i][feedIdx[i]];
                    reqLast[i]        = feedLast[i][feedIdx[i]];
                    allDone           = 1'b0;
                end else begin
                    reqValid[i]       = 1'b0;
                    reqData[8*i +: 8] = 8'h00;
                    reqLast[i]        = 1'b0;
                end
            end
            if (allDone && !busy) break;
            if (cyc >= maxCycles) begin
                failBound(name, maxCycles);
                break;
            end
            @(negedge clk);
            rdy = reqReady & reqValid;
            nextCycle();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rdy[i]) feedIdx[i]++;
            end
            cyc++;
        end
    endtask

    // Transmitter stand-in and scoreboard: checks each new frame against the
    // expected order and answers with clear_req a few cycles later.
    initial begin : monitor
        logic   prevStart;
        int     clrCnt;
        frame_t exp;
        prevStart = 1'b0;
        clrCnt = 0;
        forever begin
            @(negedge clk);
            if (txStart && !prevStart && !wbRst) begin
                if (sbQueue.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected frame: actual data 0x%0h id %0d, expected no frame", txData, grantId);
                end else begin
                    exp = sbQueue.pop_front();
                    checkOutput("frame tx_data", txData, exp.data);
                    checkOutput("frame grant_id", grantId, exp.id);
                    checkOutput("frame locked", locked, exp.isLocked);
                end
                if (autoClear) clrCnt = 5;
            end
            prevStart = txStart;
            if (autoClear) begin
                clearReq = 1'b0;
                if (clrCnt > 0) begin
                    clrCnt--;
                    if (clrCnt == 0) clearReq = 1'b1;
                end
            end else begin
                clrCnt   = 0;
                clearReq = manualClear;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [31:0] lanes;
        int          holdCycles;
        bit          badReady;
        bit          seen;

        vecs[0] = '{4'b0001, 2'd0};
        vecs[1] = '{4'b0001, 2'd0};
        vecs[2] = '{4'b1010, 2'd1};
        vecs[3] = '{4'b1010, 2'd3};
        vecs[4] = '{4'b0110, 2'd1};
        vecs[5] = '{4'b1001, 2'd3};
        vecs[6] = '{4'b1111, 2'd0};
        vecs[7] = '{4'b0100, 2'd2};
        vecs[8] = '{4'b0011, 2'd0};
        clearFeeds();

        // Reset state, with every requester valid while reset is held
        nextCycle();
        applyStimulus(4'hF, 32'h44332211, 4'hF);
        @(negedge clk);
        checkOutput("reset req_ready", reqReady, 32'h0);
        checkOutput("reset tx_start", txStart, 32'h0);
        checkOutput("reset tx_data", txData, 32'h0);
        checkOutput("reset busy", busy, 32'h0);
        checkOutput("reset grant_id", grantId, 32'h0);
        checkOutput("reset locked", locked, 32'h0);
        nextCycle();
        applyStimulus(4'h0, 32'h0, 4'h0);
        nextCycle();
        wbRst = 1'b0;

        // Single byte, hand-driven completion
        applyStimulus(4'b0001, 32'h00000041, 4'b0001);
        sbPush(2'd0, 8'h41, 1'b0);
        @(negedge clk);
        checkOutput("t1 req_ready", reqReady, 32'h1);
        nextCycle();
        applyStimulus(4'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("t1 tx_start", txStart, 32'h1);
        checkOutput("t1 tx_data", txData, 32'h41);
        nextCycle();
        nextCycle();
        manualClear = 1'b1;
        @(negedge clk);
        checkOutput("t1 tx_start before clear", txStart, 32'h1);
        nextCycle();
        manualClear = 1'b0;
        @(negedge clk);
        checkOutput("t1 tx_start after clear", txStart, 32'h0);
        checkOutput("t1 busy after clear", busy, 32'h0);
        nextCycle();

        // Arbitration table: rr_ptr evolves from 0 as each frame completes
        resetDut();
        autoClear = 1'b1;
        for (int v = 0; v < 9; v++) begin
            for (int i = 0; i < NUM_REQ; i++) lanes[8*i +: 8] = 8'((v << 4) | i);
            applyStimulus(vecs[v].valid, lanes, 4'hF);
            sbPush(vecs[v].expId, 8'((v << 4) | int'(vecs[v].expId)), 1'b0);
            @(negedge clk);
            checkOutput("table req_ready", reqReady, 32'd1 << vecs[v].expId);
            nextCycle();
            applyStimulus(4'h0, 32'h0, 4'h0);
            waitIdle(50, "table idle");
        end

        // All four continuously valid: 10,20,30,40 then 10 again
        resetDut();
        clearFeeds();
        addFeed(0, 8'h10, 1'b1);
        addFeed(0, 8'h10, 1'b1);
        addFeed(1, 8'h20, 1'b1);
        addFeed(2, 8'h30, 1'b1);
        addFeed(3, 8'h40, 1'b1);
        sbPush(2'd0, 8'h10, 1'b0);
        sbPush(2'd1, 8'h20, 1'b0);
        sbPush(2'd2, 8'h30, 1'b0);
        sbPush(2'd3, 8'h40, 1'b0);
        sbPush(2'd0, 8'h10, 1'b0);
        runRequesters(300, "t2 round robin");

        // Locked 3-byte packet from requester 2 while 1 and 3 wait
        resetDut();
        clearFeeds();
        addFeed(1, 8'h11, 1'b1);
        sbPush(2'd1, 8'h11, 1'b0);
        runRequesters(100, "t3 setup");
        clearFeeds();
        addFeed(1, 8'h12, 1'b1);
        addFeed(2, 8'hC1, 1'b0);
        addFeed(2, 8'hC2, 1'b0);
        addFeed(2, 8'hC3, 1'b1);
        addFeed(3, 8'h33, 1'b1);
        sbPush(2'd2, 8'hC1, 1'b1);
        sbPush(2'd2, 8'hC2, 1'b1);
        sbPush(2'd2, 8'hC3, 1'b0);
        sbPush(2'd3, 8'h33, 1'b0);
        sbPush(2'd1, 8'h12, 1'b0);
        runRequesters(400, "t3 packet");

        // Lock timeout: requester 1 abandons its packet, requester 2 waits
        resetDut();
        applyStimulus(4'b0110, 32'h00727100, 4'b0100);
        sbPush(2'd1, 8'h71, 1'b1);
        sbPush(2'd2, 8'h72, 1'b0);
        @(negedge clk);
        checkOutput("t4 first grant", reqReady, 32'h2);
        nextCycle();
        applyStimulus(4'b0100, 32'h00720000, 4'b0100);
        holdCycles = 0;
        badReady = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (busy && !txStart) begin
                holdCycles++;
                if (reqReady != 4'h0) badReady = 1'b1;
            end
            if (!busy) break;
        end
        checkOutput("t4 hold length", holdCycles, LOCK_TO);
        checkOutput("t4 no ready in hold", badReady, 32'h0);
        checkOutput("t4 busy after timeout", busy, 32'h0);
        checkOutput("t4 locked after timeout", locked, 32'h0);
        checkOutput("t4 waiting requester granted", reqReady, 32'h4);
        nextCycle();
        applyStimulus(4'h0, 32'h0, 4'h0);
        waitIdle(50, "t4 idle");

        // Reset during SEND, then a stray clear_req
        resetDut();
        clearFeeds();
        addFeed(1, 8'h15, 1'b1);
        sbPush(2'd1, 8'h15, 1'b0);
        runRequesters(100, "t5 setup");
        autoClear = 1'b0;
        applyStimulus(4'b0100, 32'h00E20000, 4'b0000);
        sbPush(2'd2, 8'hE2, 1'b1);
        @(negedge clk);
        checkOutput("t5 grant", reqReady, 32'h4);
        nextCycle();
        applyStimulus(4'h0, 32'h0, 4'h0);
        nextCycle();
        wbRst = 1'b1;
        nextCycle();
        wbRst = 1'b0;
        @(negedge clk);
        checkOutput("t5 tx_start after reset", txStart, 32'h0);
        checkOutput("t5 tx_data after reset", txData, 32'h0);
        checkOutput("t5 busy after reset", busy, 32'h0);
        checkOutput("t5 grant_id after reset", grantId, 32'h0);
        checkOutput("t5 locked after reset", locked, 32'h0);
        nextCycle();
        manualClear = 1'b1;
        nextCycle();
        manualClear = 1'b0;
        @(negedge clk);
        checkOutput("t5 busy after stray clear", busy, 32'h0);
        checkOutput("t5 tx_start after stray clear", txStart, 32'h0);
        nextCycle();
        autoClear = 1'b1;
        applyStimulus(4'hF, 32'h53525150, 4'hF);
        sbPush(2'd0, 8'h50, 1'b0);
        @(negedge clk);
        checkOutput("t5 rr_ptr back to 0", reqReady, 32'h1);
        nextCycle();
        applyStimulus(4'h0, 32'h0, 4'h0);
        waitIdle(50, "t5 idle");

        // Next locked byte arrives in the very cycle the timeout expires
        resetDut();
        applyStimulus(4'b1000, 32'h35000000, 4'b0000);
        sbPush(2'd3, 8'h35, 1'b1);
        sbPush(2'd3, 8'h36, 1'b0);
        sbPush(2'd0, 8'h30, 1'b0);
        @(negedge clk);
        checkOutput("t6 first grant", reqReady, 32'h8);
        nextCycle();
        applyStimulus(4'b0001, 32'h00000030, 4'b0001);
        holdCycles = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (busy && !txStart) holdCycles++;
            if (holdCycles == LOCK_TO - 1 || !busy) break;
        end
        checkOutput("t6 hold cycles before expiry", holdCycles, LOCK_TO - 1);
        nextCycle();
        applyStimulus(4'b1001, 32'h36000030, 4'b1001);
        @(negedge clk);
        checkOutput("t6 ready at expiry", reqReady, 32'h8);
        nextCycle();
        applyStimulus(4'b0001, 32'h00000030, 4'b0001);
        @(negedge clk);
        checkOutput("t6 tx_start after late accept", txStart, 32'h1);
        checkOutput("t6 grant_id kept", grantId, 32'h3);
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (reqReady[0]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) failBound("t6 requester 0 grant", 100);
        nextCycle();
        applyStimulus(4'h0, 32'h0, 4'h0);
        waitIdle(50, "t6 idle");

        checkOutput("scoreboard drained", sbQueue.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ byte-stream requesters (firmware CSR path, debug console, DMA, etc.). Round-robin arbitration per byte, with optional packet lock so a multi-byte message is not interleaved. Drives the transmitter's tx_data/tx_start inputs and consumes its clear_req completion pulse. Sits between the requesters and the transmitter inside the UART wrapper, on the Wishbone clock.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LOCK_TIMEOUT, 1024, cycles to wait for the next byte of a locked packet before the lock is released; 0 = never time out
TO_W, 16, timeout counter width; LOCK_TIMEOUT must fit in TO_W bits

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset; synchronous, active-high
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  byte is the final byte of a packet; a byte with last=0 requests the lock
req_ready  out  NUM_REQ  byte accepted; one-hot or zero; combinational
tx_data  out  8  byte to the transmitter; registered
tx_start  out  1  transmit request level to the transmitter
clear_req  in  1  one-cycle pulse from the transmitter: frame complete
busy  out  1  state != IDLE
grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
locked  out  1  the grant is held for a packet

Behaviour:
- Reset values: state=IDLE, tx_data=0, tx_start=0, rr_ptr=0, grant_id=0, locked=0, timeout count=0, req_ready=0.
- States: IDLE, SEND, HOLD.
- IDLE:
  - Grant the first requester with req_valid set, searching upward from rr_ptr with wrap-around (modulo NUM_REQ).
  - The granted requester sees req_ready=1 in the same cycle; the byte is accepted on that edge.
  - tx_data <= that byte; grant_id <= its index; locked <= ~req_last[i]; go to SEND.
  - tx_start is 1 from the next cycle. Accept-to-tx_start latency is 1 cycle.
  - No valid requester: stay in IDLE.
- SEND:
  - tx_start is held at 1 and tx_data is held stable. req_ready is all 0.
  - On clear_req, tx_start drops the next cycle.
  - If locked=0: rr_ptr <= grant_id+1 (wrap to 0 after NUM_REQ-1), then go to IDLE.
  - If locked=1: clear the timeout count, then go to HOLD.
- HOLD:
  - Only requester grant_id may be accepted. If it is valid, req_ready[grant_id]=1 that cycle.
  - On accept: tx_data <= byte; locked <= ~req_last; go to SEND.
  - Otherwise the timeout count increments each cycle.
  - When the count reaches LOCK_TIMEOUT-1 with no accept (and LOCK_TIMEOUT != 0): locked <= 0, rr_ptr <= grant_id+1, go to IDLE.
  - An accept in the same cycle as the timeout wins; no timeout is taken that cycle.
- Requester protocol: req_data/req_last must be stable while req_valid=1 and req_ready=0. A requester may deassert valid without penalty.
- clear_req is ignored in IDLE and HOLD; no state change occurs.
- A new grant can be issued in the IDLE cycle immediately after SEND. There is no bubble beyond that single IDLE cycle.
- Reset mid-operation (any state) returns every register to its reset value in the next cycle. An in-flight transmitter frame is not tracked.
- Single requester with all bytes last=1: bytes are accepted back to back, one per frame, via SEND -> IDLE -> SEND.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, SEND, HOLD);
  - default LOCK_TIMEOUT;
  - a function for index wrap (next_ptr).
- Sub-module uart_rr_arbiter: purely combinational. Takes req_valid, rr_ptr and enable; outputs a one-hot grant, the grant index and any_valid. It is reusable for a future RX-side DMA scheduler.

Test Plan:
1. Reset, then req_valid=0001 with data 0x41, last=1 -> req_ready[0] pulses in the same cycle; next cycle tx_start=1, tx_data=0x41; clear_req pulse -> tx_start=0, busy=0 one cycle later.
2. All four valid with last=1, data 0x10/0x20/0x30/0x40, clear_req 5 cycles after each tx_start -> transmit order 0x10, 0x20, 0x30, 0x40, then 0x10; grant_id sequence 0, 1, 2, 3, 0.
3. Requester 2 sends 3 bytes (last=0,0,1) while requester 1 is continuously valid -> all three of requester 2's bytes go out consecutively with locked=1 on the first two; the next grant goes to requester 3 if valid, else 0, else 1.
4. LOCK_TIMEOUT=8: requester 1 sends last=0 then drops valid -> after clear_req, HOLD lasts 8 cycles, then locked=0, busy=0; waiting requester 2 is granted next.
5. Assert wb_rst_i for one cycle during SEND -> next cycle tx_start=0, tx_data=0, state IDLE, rr_ptr=0; a subsequent clear_req causes no state change.
6. In HOLD, requester's next byte arrives in the same cycle the timeout expires -> the byte is accepted, state goes to SEND, and grant_id is unchanged.
